mccpu_debug_monitor: RTL and testbench

Board-side debug monitor for the multicycle CPU. It generates the CPU clock in either free-run (divided) or single-step (debounced push-button) mode, and counts CPU cycles. It drives the CPU's debug register select and shows PC, instruction or register contents on an 8-digit multiplexed seven-segment display. It sits between the board I/O and the CPU core, feeding the core's clock and `reg_sel` and consuming its `PC`, `instr` and `reg_data`.

---
 rtl/mccpu_dbg_pkg.sv | 35 +++
 rtl/dbg_debounce.sv | 44 ++++
 rtl/mccpu_debug_monitor.sv | 162 ++++++++++++++++
 tb/tb_mccpu_debug_monitor.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mccpu_dbg_pkg.sv
// Shared constants and helpers for the multicycle CPU debug monitor.
// Holds the display-source encodings and the hex seven-segment glyph table.
package mccpu_dbg_pkg;

  localparam logic [1:0] DISP_PC    = 2'd0;
  localparam logic [1:0] DISP_INSTR = 2'd1;
  localparam logic [1:0] DISP_REG   = 2'd2;
  localparam logic [1:0] DISP_SCAN  = 2'd3;

  // Active-low segment pattern, bit order g..a.
  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] glyph;
    case (nib)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      4'hF:    glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/dbg_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a stable-sample
// counter; the output level only moves after 2^DEB_W agreeing samples.
module dbg_debounce #(
  parameter int DEB_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic btn_db
);

  localparam logic [DEB_W-1:0] CNT_ZERO = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] CNT_MAX  = {DEB_W{1'b1}};
  localparam logic [DEB_W-1:0] CNT_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

  logic             sync1_r;
  logic             sync2_r;
  logic             db_r;
  logic [DEB_W-1:0] cnt_r;

  // Synchronize, then accept a new level once it has been seen 2^DEB_W times in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      db_r    <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      if (sync2_r == db_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_MAX) begin
        db_r  <= sync2_r;
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign btn_db = db_r;

endmodule

// File: rtl/mccpu_debug_monitor.sv
// Board-side debug monitor: CPU clock generation (free-run or single-step),
// CPU cycle counter, debug register select and 8-digit hex display scan.
module mccpu_debug_monitor
  import mccpu_dbg_pkg::*;
#(
  parameter int DIV_W  = 24,
  parameter int DEB_W  = 20,
  parameter int SCAN_W = 17,
  parameter int AUTO_W = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_btn,
  input  logic        run_mode,
  input  logic [1:0]  disp_sel,
  input  logic [4:0]  sw_reg,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] reg_data,
  output logic        cpu_clk,
  output logic [4:0]  reg_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [31:0] cycle_cnt
);

  localparam int SC_W = SCAN_W + 3;

  localparam logic [DIV_W-1:0]  DIV_MAX  = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0]  DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [AUTO_W-1:0] AUTO_MAX = {AUTO_W{1'b1}};
  localparam logic [AUTO_W-1:0] AUTO_ONE = {{(AUTO_W-1){1'b0}}, 1'b1};
  localparam logic [SC_W-1:0]   SC_MAX   = {SC_W{1'b1}};
  localparam logic [SC_W-1:0]   SC_ONE   = {{(SC_W-1){1'b0}}, 1'b1};

  logic              btn_db_s;
  logic              cpu_clk_nxt_s;
  logic [31:0]       disp_val_s;
  logic [2:0]        digit_s;
  logic [3:0]        nibble_s;

  logic              mode_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic              cpu_clk_r;
  logic              cpu_clk_d_r;
  logic [31:0]       cycle_cnt_r;
  logic [AUTO_W-1:0] auto_cnt_r;
  logic [4:0]        reg_sel_r;
  logic [SC_W-1:0]   scan_cnt_r;
  logic [31:0]       disp_r;
  logic [7:0]        an_r;
  logic [7:0]        seg_r;

  dbg_debounce #(
    .DEB_W (DEB_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst),
    .btn    (step_btn),
    .btn_db (btn_db_s)
  );

  // Next CPU clock level: divider toggle in run mode, debounced button in step mode.
  always_comb begin
    cpu_clk_nxt_s = cpu_clk_r;
    if (mode_r) begin
      if (div_cnt_r == DIV_MAX) begin
        cpu_clk_nxt_s = ~cpu_clk_r;
      end else begin
        cpu_clk_nxt_s = cpu_clk_r;
      end
    end else begin
      cpu_clk_nxt_s = btn_db_s;
    end
  end

  // Display source selection; the scan mode packs the register index into the top byte.
  always_comb begin
    disp_val_s = 32'h0000_0000;
    case (disp_sel)
      DISP_PC:    disp_val_s = pc;
      DISP_INSTR: disp_val_s = instr;
      DISP_REG:   disp_val_s = reg_data;
      DISP_SCAN:  disp_val_s = {3'b000, reg_sel_r, reg_data[23:0]};
      default:    disp_val_s = 32'h0000_0000;
    endcase
  end

  assign digit_s  = scan_cnt_r[SC_W-1:SC_W-3];
  assign nibble_s = disp_r[{digit_s, 2'b00} +: 4];

  // CPU clock generation, mode latch and cycle counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r      <= 1'b0;
      div_cnt_r   <= {DIV_W{1'b0}};
      cpu_clk_r   <= 1'b0;
      cpu_clk_d_r <= 1'b0;
      cycle_cnt_r <= 32'h0000_0000;
    end else begin
      // Mode only changes while cpu_clk is low so the high phase is never cut short.
      if (!cpu_clk_r) begin
        mode_r <= run_mode;
      end else begin
        mode_r <= mode_r;
      end
      div_cnt_r   <= div_cnt_r + DIV_ONE;
      cpu_clk_r   <= cpu_clk_nxt_s;
      cpu_clk_d_r <= cpu_clk_r;
      if (cpu_clk_r && !cpu_clk_d_r) begin
        cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
    end
  end

  // Debug register select: follows the switches, or auto-steps in scan mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_cnt_r <= {AUTO_W{1'b0}};
      reg_sel_r  <= 5'd0;
    end else begin
      auto_cnt_r <= auto_cnt_r + AUTO_ONE;
      if (disp_sel == DISP_SCAN) begin
        if (auto_cnt_r == AUTO_MAX) begin
          reg_sel_r <= reg_sel_r + 5'd1;
        end else begin
          reg_sel_r <= reg_sel_r;
        end
      end else begin
        reg_sel_r <= sw_reg;
      end
    end
  end

  // Digit scan; the value is frozen at each frame start so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_r <= {SC_W{1'b0}};
      disp_r     <= 32'h0000_0000;
      an_r       <= 8'hFF;
      seg_r      <= 8'hFF;
    end else begin
      scan_cnt_r <= scan_cnt_r + SC_ONE;
      if (scan_cnt_r == SC_MAX) begin
        disp_r <= disp_val_s;
      end else begin
        disp_r <= disp_r;
      end
      an_r  <= ~(8'h01 << digit_s);
      seg_r <= {1'b1, hex7seg(nibble_s)};
    end
  end

  assign cpu_clk   = cpu_clk_r;
  assign reg_sel   = reg_sel_r;
  assign an        = an_r;
  assign seg       = seg_r;
  assign cycle_cnt = cycle_cnt_r;

endmodule

// File: tb/tb_mccpu_debug_monitor.sv
// Directed self-checking bench for mccpu_debug_monitor with small counter widths
// (DIV_W=3, DEB_W=2, SCAN_W=2, AUTO_W=4); expected values are hand-derived.
module tb_mccpu_debug_monitor;

  logic        clk;
  logic        rst;
  logic        step_btn;
  logic        run_mode;
  logic [1:0]  disp_sel;
  logic [4:0]  sw_reg;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] reg_data;
  logic        cpu_clk;
  logic [4:0]  reg_sel;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [31:0] cycle_cnt;

  int n_checks;
  int n_fail;

  mccpu_debug_monitor #(
    .DIV_W  (3),
    .DEB_W  (2),
    .SCAN_W (2),
    .AUTO_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_btn  (step_btn),
    .run_mode  (run_mode),
    .disp_sel  (disp_sel),
    .sw_reg    (sw_reg),
    .pc        (pc),
    .instr     (instr),
    .reg_data  (reg_data),
    .cpu_clk   (cpu_clk),
    .reg_sel   (reg_sel),
    .an        (an),
    .seg       (seg),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset over a couple of edges and release between edges, so the
  // next rising edge is edge 1 after release.
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_power_on();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (cpu_clk !== 1'b0) begin n_fail++; $display("FAIL por_cpu_clk: got %0b want 0", cpu_clk); end
    n_checks++;
    if (an !== 8'hFF) begin n_fail++; $display("FAIL por_an: got %h want ff", an); end
    n_checks++;
    if (seg !== 8'hFF) begin n_fail++; $display("FAIL por_seg: got %h want ff", seg); end
    n_checks++;
    if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL por_cycle_cnt: got %0d want 0", cycle_cnt); end
    n_checks++;
    if (reg_sel !== 5'd0) begin n_fail++; $display("FAIL por_reg_sel: got %0d want 0", reg_sel); end
  endtask

  task automatic test_free_run();
    run_mode = 1'b1;
    step_btn = 1'b0;
    do_reset();
    for (int e = 1; e <= 73; e++) begin
      tick();
      if (e == 7) begin
        n_checks++;
        if (cpu_clk !== 1'b0) begin n_fail++; $display("FAIL run_low_e7: got %0b want 0", cpu_clk); end
      end
      if (e == 8) begin
        n_checks++;
        if (cpu_clk !== 1'b1) begin n_fail++; $display("FAIL run_rise_e8: got %0b want 1", cpu_clk); end
        n_checks++;
        if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL run_cnt_lag_e8: got %0d want 0", cycle_cnt); end
      end
      if (e == 9) begin
        n_checks++;
        if (cycle_cnt !== 32'd1) begin n_fail++; $display("FAIL run_cnt_e9: got %0d want 1", cycle_cnt); end
      end
      if (e == 15) begin
        n_checks++;
        if (cpu_clk !== 1'b1) begin n_fail++; $display("FAIL run_high_e15: got %0b want 1", cpu_clk); end
      end
      if (e == 16) begin
        n_checks++;
        if (cpu_clk !== 1'b0) begin n_fail++; $display("FAIL run_fall_e16: got %0b want 0", cpu_clk); end
      end
      if (e == 24) begin
        n_checks++;
        if (cpu_clk !== 1'b1) begin n_fail++; $display("FAIL run_rise_e24: got %0b want 1", cpu_clk); end
      end
      if (e == 73) begin
        n_checks++;
        if (cycle_cnt !== 32'd5) begin n_fail++; $display("FAIL run_cnt_e73: got %0d want 5", cycle_cnt); end
      end
    end
  endtask

  // Entered right after test_free_run, where cpu_clk is high (rose at edge 72).
  task automatic test_reset();
    n_checks++;
    if (cpu_clk !== 1'b1) begin n_fail++; $display("FAIL rst_precond_cpu_clk: got %0b want 1", cpu_clk); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (cpu_clk !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_clk: got %0b want 0", cpu_clk); end
    n_checks++;
    if (an !== 8'hFF) begin n_fail++; $display("FAIL rst_an: got %h want ff", an); end
    n_checks++;
    if (seg !== 8'hFF) begin n_fail++; $display("FAIL rst_seg: got %h want ff", seg); end
    n_checks++;
    if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_cycle_cnt: got %0d want 0", cycle_cnt); end
  endtask

  task automatic test_debounce();
    int  n;
    logic moved;
    run_mode = 1'b0;
    step_btn = 1'b0;
    disp_sel = 2'd0;
    do_reset();
    repeat (3) tick();
    step_btn = 1'b1;
    tick();
    tick();
    step_btn = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cpu_clk !== 1'b0) moved = 1'b1;
    end
    n_checks++;
    if (moved !== 1'b0) begin n_fail++; $display("FAIL deb_glitch: cpu_clk moved=%0b want 0", moved); end
    n_checks++;
    if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL deb_glitch_cnt: got %0d want 0", cycle_cnt); end

    step_btn = 1'b1;
    n = 31;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (cpu_clk === 1'b1) begin n = i; break; end
    end
    n_checks++;
    if (n != 7) begin n_fail++; $display("FAIL deb_press_latency: got %0d clk want 7", n); end
    repeat (12 - n) tick();
    step_btn = 1'b0;
    n = 31;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (cpu_clk === 1'b0) begin n = i; break; end
    end
    n_checks++;
    if (n != 7) begin n_fail++; $display("FAIL deb_release_latency: got %0d clk want 7", n); end
    n_checks++;
    if (cycle_cnt !== 32'd1) begin n_fail++; $display("FAIL deb_cycle_cnt: got %0d want 1", cycle_cnt); end
  endtask

  // Frame = 32 clk; the pc captured at edge 32 is shown during edges 33..64.
  task automatic test_pc_display();
    run_mode = 1'b0;
    step_btn = 1'b0;
    disp_sel = 2'd0;
    pc       = 32'h0000_3014;
    do_reset();
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (e == 34) begin
        n_checks++;
        if (an !== 8'hFE || seg !== 8'h99) begin n_fail++; $display("FAIL pc_digit0: an=%h seg=%h want fe/99", an, seg); end
      end
      if (e == 38) begin
        n_checks++;
        if (an !== 8'hFD || seg !== 8'hF9) begin n_fail++; $display("FAIL pc_digit1: an=%h seg=%h want fd/f9", an, seg); end
      end
      if (e == 42) begin
        n_checks++;
        if (an !== 8'hFB || seg !== 8'hC0) begin n_fail++; $display("FAIL pc_digit2: an=%h seg=%h want fb/c0", an, seg); end
      end
      if (e == 46) begin
        n_checks++;
        if (an !== 8'hF7 || seg !== 8'hB0) begin n_fail++; $display("FAIL pc_digit3: an=%h seg=%h want f7/b0", an, seg); end
      end
      if (e == 50) begin
        n_checks++;
        if (an !== 8'hEF || seg !== 8'hC0) begin n_fail++; $display("FAIL pc_digit4: an=%h seg=%h want ef/c0", an, seg); end
      end
      if (e == 54) begin
        n_checks++;
        if (an !== 8'hDF || seg !== 8'hC0) begin n_fail++; $display("FAIL pc_digit5: an=%h seg=%h want df/c0", an, seg); end
      end
      if (e == 58) begin
        n_checks++;
        if (an !== 8'hBF || seg !== 8'hC0) begin n_fail++; $display("FAIL pc_digit6: an=%h seg=%h want bf/c0", an, seg); end
      end
      if (e == 62) begin
        n_checks++;
        if (an !== 8'h7F || seg !== 8'hC0) begin n_fail++; $display("FAIL pc_digit7: an=%h seg=%h want 7f/c0", an, seg); end
      end
    end
  endtask

  // reg_sel loaded with 31 in mode 2, then scan mode entered after edge 16;
  // edge 32 both captures index 31 into the frame and wraps reg_sel to 0.
  task automatic test_autoscan();
    run_mode = 1'b0;
    step_btn = 1'b0;
    disp_sel = 2'd2;
    sw_reg   = 5'd31;
    reg_data = 32'h00AB_CDEF;
    do_reset();
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (e == 16) disp_sel = 2'd3;
      if (e == 1) begin
        n_checks++;
        if (reg_sel !== 5'd31) begin n_fail++; $display("FAIL scan_load_sw: got %0d want 31", reg_sel); end
      end
      if (e == 31) begin
        n_checks++;
        if (reg_sel !== 5'd31) begin n_fail++; $display("FAIL scan_hold_31: got %0d want 31", reg_sel); end
      end
      if (e == 32) begin
        n_checks++;
        if (reg_sel !== 5'd0) begin n_fail++; $display("FAIL scan_wrap: got %0d want 0", reg_sel); end
      end
      if (e == 47) begin
        n_checks++;
        if (reg_sel !== 5'd0) begin n_fail++; $display("FAIL scan_hold_0: got %0d want 0", reg_sel); end
      end
      if (e == 48) begin
        n_checks++;
        if (reg_sel !== 5'd1) begin n_fail++; $display("FAIL scan_step_1: got %0d want 1", reg_sel); end
      end
      if (e == 58) begin
        n_checks++;
        if (an !== 8'hBF || seg !== 8'h8E) begin n_fail++; $display("FAIL scan_digit6: an=%h seg=%h want bf/8e", an, seg); end
      end
      if (e == 62) begin
        n_checks++;
        if (an !== 8'h7F || seg !== 8'hF9) begin n_fail++; $display("FAIL scan_digit7: an=%h seg=%h want 7f/f9", an, seg); end
      end
      if (e == 64) begin
        n_checks++;
        if (reg_sel !== 5'd2) begin n_fail++; $display("FAIL scan_step_2: got %0d want 2", reg_sel); end
      end
    end
    disp_sel = 2'd0;
  endtask

  // run_mode dropped after edge 9 while cpu_clk is high (rose at edge 8).
  task automatic test_mode_change();
    int highs;
    int n;
    run_mode = 1'b1;
    step_btn = 1'b0;
    do_reset();
    highs = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 9) run_mode = 1'b0;
      if (cpu_clk === 1'b1) highs++;
      if (e == 15) begin
        n_checks++;
        if (cpu_clk !== 1'b1) begin n_fail++; $display("FAIL mode_high_e15: got %0b want 1", cpu_clk); end
      end
      if (e == 16) begin
        n_checks++;
        if (cpu_clk !== 1'b0) begin n_fail++; $display("FAIL mode_fall_e16: got %0b want 0", cpu_clk); end
      end
      if (e == 24) begin
        n_checks++;
        if (cpu_clk !== 1'b0) begin n_fail++; $display("FAIL mode_step_e24: got %0b want 0", cpu_clk); end
      end
    end
    n_checks++;
    if (highs != 8) begin n_fail++; $display("FAIL mode_high_width: got %0d clk want 8", highs); end
    step_btn = 1'b1;
    n = 31;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (cpu_clk === 1'b1) begin n = i; break; end
    end
    n_checks++;
    if (n != 7) begin n_fail++; $display("FAIL mode_step_press: got %0d clk want 7", n); end
    step_btn = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    step_btn = 1'b0;
    run_mode = 1'b0;
    disp_sel = 2'd0;
    sw_reg   = 5'd0;
    pc       = 32'h0000_0000;
    instr    = 32'h0000_0000;
    reg_data = 32'h0000_0000;

    test_power_on();
    test_free_run();
    test_reset();
    test_debounce();
    test_pc_display();
    test_autoscan();
    test_mode_change();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
